// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V writeback stage: element width, FIFO entry
// layout and the element-to-VRF-word packing function.
package rv32v_types_pkg;

   localparam int VLEN_BYTES = 16;

   typedef enum logic [1:0] {
      EEW8  = 2'd0,
      EEW16 = 2'd1,
      EEW32 = 2'd2
   } eew_t;

   typedef struct packed {
      logic [4:0]  vd;
      logic [7:0]  woffset;
      logic [31:0] data;
      eew_t        eew;
      logic        last;
   } wb_entry_t;

   typedef struct packed {
      logic [4:0]  sel;
      logic [7:0]  word;
      logic [31:0] wdata;
      logic [3:0]  byte_ena;
   } vrf_req_t;

   // bytes_log2 is log2 of the register size in bytes; the word index keeps
   // only the bits below that, the rest carries into the register number.
   function automatic vrf_req_t pack_entry(input wb_entry_t e, input int unsigned bytes_log2);
      vrf_req_t   r;
      logic [9:0] byte_addr;
      logic [1:0] sh;
      byte_addr  = {2'b00, e.woffset} << e.eew;
      sh         = byte_addr[1:0];
      r.sel      = e.vd + 5'(byte_addr >> bytes_log2);
      r.word     = 8'((byte_addr >> 2) & ((10'd1 << (bytes_log2 - 2)) - 10'd1));
      r.wdata    = e.data << {sh, 3'b000};
      case (e.eew)
         EEW8:    r.byte_ena = 4'b0001 << sh;
         EEW16:   r.byte_ena = 4'b0011 << sh;
         default: r.byte_ena = 4'b1111;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rv32v_wb_fifo.sv
// DEPTH-entry FIFO of writeback entries: up to two pushes and one pop per cycle.
module rv32v_wb_fifo
   import rv32v_types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [1:0]               push_cnt,
   input  wb_entry_t                push_a,
   input  wb_entry_t                push_b,
   input  logic                     pop,
   output wb_entry_t                head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t        mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;

   assign head = mem[rptr];

   // Storage needs no reset: the count decides which slots are meaningful.
   always_ff @(posedge CLK) begin
      if (push_cnt != 2'd0) mem[wptr] <= push_a;
      if (push_cnt == 2'd2) mem[wptr + PW'(1)] <= push_b;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + PW'(push_cnt);
         rptr  <= rptr + PW'(pop);
         count <= count + CW'(push_cnt) - CW'(pop);
      end
   end

endmodule

// File: rtl/rv32v_writeback_stage.sv
// RV32V writeback: buffers memory-stage lanes, drains one byte-enabled VRF
// word write per cycle, forwards the scalar rd result and signals completion.
module rv32v_writeback_stage
   import rv32v_types_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int VLEN  = 128
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   in_wen,
   input  logic [4:0]                   in_vd,
   input  logic [7:0]                   in_woffset0,
   input  logic [7:0]                   in_woffset1,
   input  logic [31:0]                  in_wdat0,
   input  logic [31:0]                  in_wdat1,
   input  logic [1:0]                   in_eew,
   input  logic                         in_done,
   input  logic                         in_rd_wen,
   input  logic [4:0]                   in_rd_sel,
   input  logic [31:0]                  in_rd_data,
   output logic                         vrf_wen,
   output logic [4:0]                   vrf_sel,
   output logic [$clog2(VLEN/32)-1:0]   vrf_word,
   output logic [31:0]                  vrf_wdata,
   output logic [3:0]                   vrf_byte_ena,
   input  logic                         vrf_busy,
   output logic                         rd_wen,
   output logic [4:0]                   rd_sel,
   output logic [31:0]                  rd_data,
   output logic                         done,
   output logic                         empty
);

   localparam int WORD_W     = $clog2(VLEN / 32);
   localparam int BYTES_LOG2 = $clog2(VLEN / 8);
   localparam int CW         = $clog2(DEPTH) + 1;

   logic            accept;
   logic            pop;
   logic [1:0]      push_cnt;
   logic            done_pending;
   wb_entry_t       lane0;
   wb_entry_t       lane1;
   wb_entry_t       push_a;
   wb_entry_t       head;
   logic [CW-1:0]   count;
   vrf_req_t        req;

   // Two lanes can arrive per cycle, so hold off unless two slots are free.
   assign in_ready = (count <= CW'(DEPTH - 2));
   assign accept   = in_valid & in_ready;
   assign pop      = (count != '0) & ~vrf_busy;
   assign push_cnt = accept ? ({1'b0, in_wen[0]} + {1'b0, in_wen[1]}) : 2'd0;

   assign lane0 = '{vd: in_vd, woffset: in_woffset0, data: in_wdat0,
                    eew: eew_t'(in_eew), last: in_done & ~in_wen[1]};
   assign lane1 = '{vd: in_vd, woffset: in_woffset1, data: in_wdat1,
                    eew: eew_t'(in_eew), last: in_done};
   assign push_a = in_wen[0] ? lane0 : lane1;

   rv32v_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .push_cnt (push_cnt),
      .push_a   (push_a),
      .push_b   (lane1),
      .pop      (pop),
      .head     (head),
      .count    (count)
   );

   assign req   = pack_entry(head, BYTES_LOG2);
   assign empty = (count == '0) & ~done_pending & ~vrf_wen;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vrf_wen      <= 1'b0;
         vrf_sel      <= '0;
         vrf_word     <= '0;
         vrf_wdata    <= '0;
         vrf_byte_ena <= '0;
         done         <= 1'b0;
         done_pending <= 1'b0;
      end else begin
         vrf_wen <= pop;
         done    <= 1'b0;
         if (pop) begin
            vrf_sel      <= req.sel;
            vrf_word     <= WORD_W'(req.word);
            vrf_wdata    <= req.wdata;
            vrf_byte_ena <= req.byte_ena;
            done         <= head.last;
         end
         // An element-less final bundle completes once earlier lanes are gone.
         if (done_pending && count == '0) begin
            done         <= 1'b1;
            done_pending <= 1'b0;
         end else if (accept && in_done && in_wen == 2'b00) begin
            done_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_wen  <= 1'b0;
         rd_sel  <= '0;
         rd_data <= '0;
      end else begin
         rd_wen <= accept & in_rd_wen;
         if (accept) begin
            rd_sel  <= in_rd_sel;
            rd_data <= in_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_rv32v_writeback_stage.sv
// Directed bench for rv32v_writeback_stage with hand-computed VRF/scalar results.
module tb_rv32v_writeback_stage;

   logic        CLK;
   logic        RST;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_wen;
   logic [4:0]  in_vd;
   logic [7:0]  in_woffset0;
   logic [7:0]  in_woffset1;
   logic [31:0] in_wdat0;
   logic [31:0] in_wdat1;
   logic [1:0]  in_eew;
   logic        in_done;
   logic        in_rd_wen;
   logic [4:0]  in_rd_sel;
   logic [31:0] in_rd_data;
   logic        vrf_wen;
   logic [4:0]  vrf_sel;
   logic [1:0]  vrf_word;
   logic [31:0] vrf_wdata;
   logic [3:0]  vrf_byte_ena;
   logic        vrf_busy;
   logic        rd_wen;
   logic [4:0]  rd_sel;
   logic [31:0] rd_data;
   logic        done;
   logic        empty;

   int n_checks;
   int n_errors;

   rv32v_writeback_stage #(.DEPTH(4), .VLEN(128)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_wen       (in_wen),
      .in_vd        (in_vd),
      .in_woffset0  (in_woffset0),
      .in_woffset1  (in_woffset1),
      .in_wdat0     (in_wdat0),
      .in_wdat1     (in_wdat1),
      .in_eew       (in_eew),
      .in_done      (in_done),
      .in_rd_wen    (in_rd_wen),
      .in_rd_sel    (in_rd_sel),
      .in_rd_data   (in_rd_data),
      .vrf_wen      (vrf_wen),
      .vrf_sel      (vrf_sel),
      .vrf_word     (vrf_word),
      .vrf_wdata    (vrf_wdata),
      .vrf_byte_ena (vrf_byte_ena),
      .vrf_busy     (vrf_busy),
      .rd_wen       (rd_wen),
      .rd_sel       (rd_sel),
      .rd_data      (rd_data),
      .done         (done),
      .empty        (empty)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [1:0] wen, input logic [4:0] vd, input logic [1:0] eew,
                        input logic [7:0] off0, input logic [31:0] d0,
                        input logic [7:0] off1, input logic [31:0] d1, input logic dn);
      in_valid    = 1'b1;
      in_wen      = wen;
      in_vd       = vd;
      in_eew      = eew;
      in_woffset0 = off0;
      in_wdat0    = d0;
      in_woffset1 = off1;
      in_wdat1    = d1;
      in_done     = dn;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      in_wen    = 2'b00;
      in_done   = 1'b0;
      in_rd_wen = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic [4:0] sel, input logic [1:0] word,
                              input logic [3:0] ena, input logic [31:0] data);
      check({tag, ".wen"},  32'(vrf_wen), 32'd1);
      check({tag, ".sel"},  32'(vrf_sel), 32'(sel));
      check({tag, ".word"}, 32'(vrf_word), 32'(word));
      check({tag, ".ena"},  32'(vrf_byte_ena), 32'(ena));
      check({tag, ".data"}, vrf_wdata, data);
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      RST        = 1'b1;
      vrf_busy   = 1'b0;
      in_vd      = '0;
      in_eew     = '0;
      in_woffset0 = '0;
      in_woffset1 = '0;
      in_wdat0   = '0;
      in_wdat1   = '0;
      in_rd_sel  = '0;
      in_rd_data = '0;
      idle();
      step();
      step();
      check("rst.vrf_wen",  32'(vrf_wen), 32'd0);
      check("rst.empty",    32'(empty), 32'd1);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.done",     32'(done), 32'd0);
      check("rst.rd_wen",   32'(rd_wen), 32'd0);
      RST = 1'b0;
      step();

      // Single 32-bit lane: reg 4 + 20/16 = 5, word 1.
      drive(2'b01, 5'd4, 2'd2, 8'd5, 32'hDEADBEEF, 8'd0, 32'h0, 1'b0);
      step();
      idle();
      check("single.no_bypass", 32'(vrf_wen), 32'd0);
      check("single.empty", 32'(empty), 32'd0);
      step();
      check_write("single", 5'd5, 2'd1, 4'b1111, 32'hDEADBEEF);
      check("single.done", 32'(done), 32'd0);
      step();
      check("single.wen_off", 32'(vrf_wen), 32'd0);
      check("single.empty_after", 32'(empty), 32'd1);

      // Byte packing: offsets 6 and 7 of v2 land in word 1, bytes 2 and 3.
      drive(2'b11, 5'd2, 2'd0, 8'd6, 32'h000000AB, 8'd7, 32'h000000CD, 1'b0);
      step();
      idle();
      step();
      check_write("byte0", 5'd2, 2'd1, 4'b0100, 32'h00AB0000);
      step();
      check_write("byte1", 5'd2, 2'd1, 4'b1000, 32'hCD000000);
      step();
      check("byte.wen_off", 32'(vrf_wen), 32'd0);

      // Lane1-only, 16-bit: offset 9 -> byte 18 -> reg 4, word 0, upper half.
      drive(2'b10, 5'd3, 2'd1, 8'd0, 32'h0, 8'd9, 32'h0000BEEF, 1'b0);
      step();
      idle();
      step();
      check_write("lane1only", 5'd4, 2'd0, 4'b1100, 32'hBEEF0000);
      step();

      // Backpressure: four lanes with the VRF busy.
      vrf_busy = 1'b1;
      drive(2'b11, 5'd8, 2'd2, 8'd0, 32'h11111111, 8'd1, 32'h22222222, 1'b0);
      step();
      check("bp.ready_two_free", 32'(in_ready), 32'd1);
      drive(2'b11, 5'd8, 2'd2, 8'd2, 32'h33333333, 8'd3, 32'h44444444, 1'b0);
      step();
      idle();
      check("bp.ready_full", 32'(in_ready), 32'd0);
      check("bp.wen_stalled", 32'(vrf_wen), 32'd0);
      step();
      check("bp.hold_sel", 32'(vrf_sel), 32'd4);
      check("bp.hold_data", vrf_wdata, 32'hBEEF0000);
      check("bp.still_full", 32'(in_ready), 32'd0);
      vrf_busy = 1'b0;
      step();
      check_write("bp.w0", 5'd8, 2'd0, 4'b1111, 32'h11111111);
      step();
      check_write("bp.w1", 5'd8, 2'd1, 4'b1111, 32'h22222222);
      step();
      check_write("bp.w2", 5'd8, 2'd2, 4'b1111, 32'h33333333);
      step();
      check_write("bp.w3", 5'd8, 2'd3, 4'b1111, 32'h44444444);
      check("bp.ready_after", 32'(in_ready), 32'd1);
      step();
      check("bp.wen_off", 32'(vrf_wen), 32'd0);

      // Mid-drain stall: held values, no strobe.
      drive(2'b11, 5'd1, 2'd2, 8'd4, 32'hA5A5A5A5, 8'd5, 32'h5A5A5A5A, 1'b0);
      step();
      idle();
      step();
      check_write("stall.w0", 5'd2, 2'd0, 4'b1111, 32'hA5A5A5A5);
      vrf_busy = 1'b1;
      step();
      check("stall.wen", 32'(vrf_wen), 32'd0);
      check("stall.hold", vrf_wdata, 32'hA5A5A5A5);
      vrf_busy = 1'b0;
      step();
      check_write("stall.w1", 5'd2, 2'd1, 4'b1111, 32'h5A5A5A5A);
      step();

      // Completion on a two-lane final bundle: done only with lane1.
      drive(2'b11, 5'd12, 2'd2, 8'd0, 32'hCAFE0000, 8'd1, 32'hCAFE0001, 1'b1);
      step();
      idle();
      check("done2.none_yet", 32'(done), 32'd0);
      step();
      check("done2.lane0_wen", 32'(vrf_wen), 32'd1);
      check("done2.lane0_nodone", 32'(done), 32'd0);
      step();
      check_write("done2.lane1", 5'd12, 2'd1, 4'b1111, 32'hCAFE0001);
      check("done2.pulse", 32'(done), 32'd1);
      step();
      check("done2.single", 32'(done), 32'd0);
      check("done2.empty", 32'(empty), 32'd1);

      // Completion with no elements into an empty FIFO.
      drive(2'b00, 5'd0, 2'd2, 8'd0, 32'h0, 8'd0, 32'h0, 1'b1);
      step();
      idle();
      check("done0.pending", 32'(done), 32'd0);
      check("done0.not_empty", 32'(empty), 32'd0);
      step();
      check("done0.pulse", 32'(done), 32'd1);
      check("done0.no_write", 32'(vrf_wen), 32'd0);
      step();
      check("done0.single", 32'(done), 32'd0);
      check("done0.empty", 32'(empty), 32'd1);

      // Scalar path while FIFO is filling, then reset mid-operation.
      vrf_busy = 1'b1;
      drive(2'b11, 5'd6, 2'd2, 8'd0, 32'h1, 8'd1, 32'h2, 1'b0);
      step();
      drive(2'b01, 5'd6, 2'd2, 8'd2, 32'h3, 8'd0, 32'h0, 1'b0);
      in_rd_wen  = 1'b1;
      in_rd_sel  = 5'd10;
      in_rd_data = 32'h1234;
      step();
      idle();
      check("rd.wen", 32'(rd_wen), 32'd1);
      check("rd.sel", 32'(rd_sel), 32'd10);
      check("rd.data", rd_data, 32'h1234);
      check("rd.fifo_full", 32'(in_ready), 32'd0);
      step();
      check("rd.wen_drop", 32'(rd_wen), 32'd0);
      RST = 1'b1;
      #2;
      check("rstmid.async_ready", 32'(in_ready), 32'd1);
      check("rstmid.async_empty", 32'(empty), 32'd1);
      step();
      vrf_busy = 1'b0;
      RST      = 1'b0;
      check("rstmid.vrf_wen", 32'(vrf_wen), 32'd0);
      check("rstmid.done", 32'(done), 32'd0);
      step();
      check("rstmid.no_write", 32'(vrf_wen), 32'd0);
      check("rstmid.empty", 32'(empty), 32'd1);
      check("rstmid.ready", 32'(in_ready), 32'd1);
      step();
      check("rstmid.no_write2", 32'(vrf_wen), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rv32v_writeback_stage.md
Name: rv32v_writeback_stage

Overview:
- Vector writeback stage; sits directly downstream of the RV32V memory stage and consumes its two-lane result bundle (wdat0/wdat1, woffset0/1, per-lane wen, vd, eew, done).
- Packs each lane element into a byte-enabled 32-bit vector register file (VRF) word write through a single VRF write port, buffering lanes in a small FIFO.
- Forwards the scalar rd result to the scalar unit and signals instruction completion once the last element has reached the VRF.

Parameters:
- DEPTH, 4, FIFO entries (each entry is one lane write); power of two, minimum 2.
- VLEN, 128, bits per vector register.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- in_valid  in  1  memory stage presents a result bundle this cycle.
- in_ready  out  1  stage can accept a bundle; asserted when at least 2 FIFO entries are free.
- in_wen  in  2  per-lane element write enable (bit0 = lane0, bit1 = lane1).
- in_vd  in  5  destination register, base of the register group.
- in_woffset0  in  8  lane0 element index within the group.
- in_woffset1  in  8  lane1 element index within the group.
- in_wdat0  in  32  lane0 element data, right-aligned.
- in_wdat1  in  32  lane1 element data, right-aligned.
- in_eew  in  2  element width: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit; 3 is reserved.
- in_done  in  1  this bundle carries the final elements of the instruction.
- in_rd_wen  in  1  scalar write request.
- in_rd_sel  in  5  scalar destination register.
- in_rd_data  in  32  scalar data.
- vrf_wen  out  1  VRF write strobe.
- vrf_sel  out  5  VRF register number.
- vrf_word  out  $clog2(VLEN/32)  word index within the register.
- vrf_wdata  out  32  element data shifted into its byte lanes.
- vrf_byte_ena  out  4  VRF byte enables.
- vrf_busy  in  1  VRF cannot accept a write this cycle.
- rd_wen  out  1  scalar write strobe to the scalar unit.
- rd_sel  out  5  scalar destination register.
- rd_data  out  32  scalar data.
- done  out  1  one-cycle completion pulse.
- empty  out  1  FIFO empty and no completion pending; used by the hazard unit.

Behaviour:
- Reset: all outputs are 0 except in_ready = 1 and empty = 1; FIFO pointers, count and the done-pending flag are cleared. A reset asserted mid-drain discards all buffered entries; no VRF write issues in the following cycle.
- Accept: a bundle is taken when in_valid & in_ready.
  - Each lane with in_wen[i] = 1 is pushed; lane0 is always pushed before lane1.
  - A bundle with in_wen = 00 pushes nothing. If it carries in_done = 1, done-pending is still set.
  - A bundle arriving while in_ready = 0 is not accepted; the memory stage holds it.
- Entry contents: vd, woffset, data, eew, last. The last flag is set on the final lane pushed from a bundle with in_done = 1.
- Address math, per entry:
  - byte_addr = woffset << eew.
  - reg = vd + byte_addr / (VLEN/8).
  - word = byte_addr[log2(VLEN/8)-1:2].
  - shift = byte_addr[1:0].
  - vrf_wdata = data << (8*shift).
  - vrf_byte_ena: eew 0 gives 0001 << shift; eew 1 gives 0011 << shift; eew 2 gives 1111.
  - A misaligned 16-bit shift (shift odd) is not produced by the memory stage and is not checked.
- Drain: when the FIFO is non-empty and vrf_busy = 0, the head entry is popped. vrf_* are registered outputs, valid one cycle after the pop. At most one VRF write is issued per cycle.
- Throughput: 2 lanes in versus 1 lane out per cycle, so in_ready deasserts when free entries < 2. Push and pop in the same cycle are permitted; count updates by +pushes − pop.
- Wrap-around: pointers are $clog2(DEPTH) bits with natural wrap; full/empty is derived from a separate count register.
- Completion:
  - Popping an entry with last = 1 pulses done in the same cycle that vrf_wen = 1 for that entry.
  - A done-pending flag set by an all-disabled in_done bundle pulses done once the FIFO is empty.
  - done never pulses twice for one in_done.
- Scalar path: rd_* are registered from in_rd_* on an accepted bundle, with 1-cycle latency, and are independent of the FIFO. rd_wen is 0 in any cycle with no accepted bundle.
- Simultaneous events:
  - A push into an empty FIFO with vrf_busy = 0 does not bypass the FIFO; minimum latency is 2 cycles from accept to vrf_wen.
  - vrf_busy holds the head entry. vrf_wen drops to 0 while stalled, and vrf_* values are held.
- empty = (count == 0) & ~done_pending & ~vrf_wen.

Decomposition:
- Shared package rv32v_types_pkg holds:
  - eew_t enum (EEW8, EEW16, EEW32).
  - wb_entry_t struct {vd, woffset, data, eew, last}.
  - VLEN_BYTES constant.
- One natural sub-module: rv32v_wb_fifo, a generic DEPTH-entry FIFO of wb_entry_t with dual push and single pop. Address/byte-enable packing is a function in the package.

Test Plan:
- Reset mid-operation: fill 3 entries, assert RST → next cycle vrf_wen = 0, empty = 1, in_ready = 1, no done.
- Single 32-bit lane: eew = 2, vd = 4, woffset0 = 5, wdat0 = 0xDEADBEEF, in_wen = 01 → two cycles later vrf_sel = 5, vrf_word = 1, vrf_byte_ena = 1111, vrf_wdata = 0xDEADBEEF.
- Byte packing: eew = 0, vd = 2, woffsets 6/7, data 0xAB/0xCD, in_wen = 11 → consecutive writes:
  - reg 2, word 1, ena 0100, data 0x00AB0000.
  - then ena 1000, data 0xCD000000.
- Backpressure: vrf_busy = 1 with 4 lanes pushed → in_ready = 0 and vrf_* held. Release vrf_busy → 4 writes on 4 consecutive cycles, then in_ready = 1.
- Completion: the final bundle has in_done = 1 with in_wen = 11 → exactly one done pulse, coincident with lane1's write. A second case with in_done = 1 and in_wen = 00 into an empty FIFO → done the next cycle.
- Scalar path: in_rd_wen = 1, rd_sel = 10, rd_data = 0x1234 → one cycle later rd_wen = 1 with the same values, irrespective of FIFO state.
